// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle sequencer for the 4-bit-opcode datapath
//
// Purpose:
//   Fetches each instruction over a req/ack handshake, steps through
//   FETCH -> DECODE -> EXEC -> WB, and drives PC, IR, register-file and
//   ALU controls. It also counts retired instructions and traps fetch stalls.
//
// Ports:
//   clk          in   clock; all state updates on the rising edge
//   rst_n        in   synchronous active-low reset
//   imem_req     out  fetch request, high for the whole FETCH state
//   imem_ack     in   fetch done; instr_opcode is valid in this cycle
//   instr_opcode in   opcode field of the fetched instruction
//   zero         in   ALU zero flag, sampled in EXEC of beq
//   ir_load      out  pulse: load the instruction register
//   pc_inc       out  pulse: PC <= PC + 1
//   pc_branch    out  pulse: PC <= branch target
//   reg_write    out  pulse: register-file write (WB only)
//   alu_src      out  0 = register operand, 1 = immediate
//   alu_control  out  00 and, 01 or, 10 add, 11 sub
//   retired      out  pulse per completed instruction
//   retire_count out  retired-instruction count, wraps modulo 2^CNT_W
//   fault        out  sticky fetch timeout / illegal-op trap
//   state_o      out  current state code, for debug
//
// Build option:
//   ILLEGAL_TRAP_EN  when defined, opcodes 8-15 trap to FAULT from EXEC;
//                    when undefined, they retire as NOPs.

module multicycle_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [3:0]       instr_opcode,
  input  logic             zero,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_branch,
  output logic             reg_write,
  output logic             alu_src,
  output logic [1:0]       alu_control,
  output logic             retired,
  output logic [CNT_W-1:0] retire_count,
  output logic             fault,
  output logic [2:0]       state_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd7;

  // The counter only has to reach TIMEOUT-1.
  localparam int            TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [TW-1:0] to_cnt;
  logic [3:0]    op_q;
  logic          is_beq;
  logic          is_alu;

  assign is_beq = (op_q == 4'd7);
  assign is_alu = ~op_q[3] & ~is_beq;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      // An ack in the last allowed cycle takes priority over the timeout.
      S_FETCH: begin
        if (imem_ack)
          state_nxt = S_DECODE;
        else if (to_cnt == TO_LAST)
          state_nxt = S_FAULT;
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (is_alu)
          state_nxt = S_WB;
        else if (is_beq)
          state_nxt = S_FETCH;
        else begin
`ifdef ILLEGAL_TRAP_EN
          state_nxt = S_FAULT;
`else
          state_nxt = S_FETCH;
`endif
        end
      end
      S_WB:     state_nxt = S_FETCH;
      S_FAULT:  state_nxt = S_FAULT;
      default:  state_nxt = S_FAULT;
    endcase
  end

  assign imem_req = (state == S_FETCH);
  assign fault    = (state == S_FAULT);
  assign state_o  = state;

  // Pulses are masked while rst_n is low so a reset landing mid-instruction
  // never lets a write or PC update escape in the cycle it is asserted.
  always_comb begin
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_branch = 1'b0;
    reg_write = 1'b0;
    retired   = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: ir_load = imem_ack;
        S_EXEC: begin
          if (is_beq) begin
            pc_branch = zero;
            pc_inc    = ~zero;
            retired   = 1'b1;
          end else if (!is_alu) begin
`ifdef ILLEGAL_TRAP_EN
            retired   = 1'b0;
`else
            pc_inc    = 1'b1;
            retired   = 1'b1;
`endif
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          pc_inc    = 1'b1;
          retired   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      to_cnt       <= '0;
      op_q         <= '0;
      alu_src      <= 1'b0;
      alu_control  <= 2'b00;
      retire_count <= '0;
    end else begin
      state <= state_nxt;

      if (state == S_FETCH) begin
        if (imem_ack) begin
          op_q   <= instr_opcode;
          to_cnt <= '0;
        end else if (to_cnt != TO_LAST) begin
          to_cnt <= to_cnt + 1'b1;
        end
      end

      // Decode is registered so ALU controls are stable from EXEC onward
      // and hold until the next DECODE.
      if (state == S_DECODE) begin
        if (op_q[3]) begin
          alu_src     <= 1'b0;
          alu_control <= 2'b00;
        end else if (is_beq) begin
          alu_src     <= 1'b0;
          alu_control <= 2'b11;
        end else begin
          alu_src     <= op_q[2];
          alu_control <= op_q[1:0];
        end
      end

      if (retired)
        retire_count <= retire_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl

module tb_multicycle_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          imem_req;
  logic          imem_ack;
  logic [3:0]    instr_opcode;
  logic          zero;
  logic          ir_load;
  logic          pc_inc;
  logic          pc_branch;
  logic          reg_write;
  logic          alu_src;
  logic [1:0]    alu_control;
  logic          retired;
  logic [CW-1:0] retire_count;
  logic          fault;
  logic [2:0]    state_o;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  multicycle_ctrl #(.TIMEOUT(15), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_ack(imem_ack),
    .instr_opcode(instr_opcode), .zero(zero), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_branch(pc_branch), .reg_write(reg_write),
    .alu_src(alu_src), .alu_control(alu_control), .retired(retired),
    .retire_count(retire_count), .fault(fault), .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic check_pulses(input string tag, input logic [3:0] exp_rw_pi_pb_rt);
    check({tag, ".reg_write"}, reg_write, exp_rw_pi_pb_rt[3]);
    check({tag, ".pc_inc"},    pc_inc,    exp_rw_pi_pb_rt[2]);
    check({tag, ".pc_branch"}, pc_branch, exp_rw_pi_pb_rt[1]);
    check({tag, ".retired"},   retired,   exp_rw_pi_pb_rt[0]);
  endtask

  // Ends in DECODE, 2 ns after the edge.
  task automatic fetch(input logic [3:0] op, input int waits);
    for (int i = 0; i < waits; i++) begin
      imem_ack = 1'b0;
      #1;
      check("fetch_wait.req", imem_req, 1'b1);
      check("fetch_wait.ir_load", ir_load, 1'b0);
      tick();
    end
    imem_ack = 1'b1;
    instr_opcode = op;
    #1;
    check("fetch.state", state_o, 3'd1);
    check("fetch.ir_load", ir_load, 1'b1);
    tick();
    imem_ack = 1'b0;
  endtask

  // kind: 0 = ALU op, 1 = beq, 2 = op 8-15
  task automatic run_instr(input logic [3:0] op, input int waits, input int kind,
                           input logic zv, input logic exp_src, input logic [1:0] exp_ctrl);
    fetch(op, waits);
    zero = zv;
    #1;
    check("decode.state", state_o, 3'd2);
    check_pulses("decode", 4'b0000);
    tick();
    #1;
    check("exec.state", state_o, 3'd3);
    check("exec.alu_src", alu_src, exp_src);
    check("exec.alu_control", alu_control, exp_ctrl);
    if (kind == 0) begin
      check_pulses("exec_alu", 4'b0000);
      tick();
      #1;
      check("wb.state", state_o, 3'd4);
      check("wb.alu_control", alu_control, exp_ctrl);
      check_pulses("wb", 4'b1101);
      exp_cnt++;
    end else if (kind == 1) begin
      check_pulses("exec_beq", {1'b0, ~zv, zv, 1'b1});
      exp_cnt++;
    end else begin
`ifdef ILLEGAL_TRAP_EN
      check_pulses("exec_trap", 4'b0000);
      tick();
      #1;
      check("trap.state", state_o, 3'd7);
      check("trap.fault", fault, 1'b1);
      check("trap.count", retire_count, exp_cnt % 16);
      return;
`else
      check_pulses("exec_nop", 4'b0101);
      exp_cnt++;
`endif
    end
    tick();
    #1;
    check("retire.state", state_o, 3'd1);
    check("retire.count", retire_count, exp_cnt % 16);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    imem_ack = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_cnt = 0;
    #1;
    check("reset.state", state_o, 3'd0);
    check("reset.req", imem_req, 1'b0);
    check("reset.fault", fault, 1'b0);
    check("reset.count", retire_count, 0);
    check("reset.alu", {alu_src, alu_control}, 3'b000);
    check_pulses("reset", 4'b0000);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    imem_ack = 1'b0;
    instr_opcode = 4'd0;
    zero = 1'b0;
    tick();
    do_reset();
    #1;
    check("idle_exit.req", imem_req, 1'b1);
    check("idle_exit.state", state_o, 3'd1);

    run_instr(4'd2, 0, 0, 1'b0, 1'b0, 2'b10);   // add
    run_instr(4'd7, 0, 1, 1'b1, 1'b0, 2'b11);   // beq taken
    run_instr(4'd7, 0, 1, 1'b0, 1'b0, 2'b11);   // beq not taken
    run_instr(4'd6, 14, 0, 1'b0, 1'b1, 2'b10);  // addi after 14 waits
    run_instr(4'd1, 0, 0, 1'b0, 1'b0, 2'b01);   // or
    run_instr(4'd9, 0, 2, 1'b0, 1'b0, 2'b00);   // illegal / nop

    // Fetch timeout: 15 cycles without ack.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      imem_ack = 1'b0;
      #1;
      check("stall.req", imem_req, 1'b1);
      tick();
    end
    #1;
    check("timeout.state", state_o, 3'd7);
    check("timeout.fault", fault, 1'b1);
    check("timeout.req", imem_req, 1'b0);
    imem_ack = 1'b1;
    tick();
    tick();
    #1;
    check("timeout.sticky", fault, 1'b1);
    check("timeout.ir_load", ir_load, 1'b0);

    // Counter wrap at 2^CW.
    do_reset();
    for (int i = 0; i < 17; i++)
      run_instr(4'd5, 0, 0, 1'b0, 1'b1, 2'b01);
    check("wrap.count", retire_count, 4'd1);

    // Reset during DECODE abandons the instruction.
    fetch(4'd5, 0);
    rst_n = 1'b0;
    #1;
    check_pulses("rst_decode", 4'b0000);
    tick();
    rst_n = 1'b1;
    imem_ack = 1'b1;
    #1;
    check("rst_decode.state", state_o, 3'd0);
    check("rst_decode.count", retire_count, 0);
    check("idle_ack.ir_load", ir_load, 1'b0);
    tick();
    imem_ack = 1'b0;
    #1;
    check("idle_ack.state", state_o, 3'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
